// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences each instruction over several cycles, owns
// the status-flag register, waits on the memory ready handshake and traps bad opcodes.
module multicycle_control #(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6,
    parameter int FLAG_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    opcode,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               mem_ready,
    input  logic [FLAG_W-1:0]  alu_flags,
    output logic               pc_write,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               link_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic [FLAG_W-1:0]  status_flags,
    output logic               instr_done,
    output logic               illegal
);
    localparam logic [4:0] FETCH    = 5'd0;
    localparam logic [4:0] DECODE   = 5'd1;
    localparam logic [4:0] EXEC_R   = 5'd2;
    localparam logic [4:0] WB_R     = 5'd3;
    localparam logic [4:0] EXEC_I   = 5'd4;
    localparam logic [4:0] WB_I     = 5'd5;
    localparam logic [4:0] MEM_ADDR = 5'd6;
    localparam logic [4:0] MEM_RD   = 5'd7;
    localparam logic [4:0] MEM_WB   = 5'd8;
    localparam logic [4:0] MEM_WR   = 5'd9;
    localparam logic [4:0] BEQ      = 5'd10;
    localparam logic [4:0] JALPC    = 5'd11;
    localparam logic [4:0] BALV     = 5'd12;
    localparam logic [4:0] BLEZAL   = 5'd13;
    localparam logic [4:0] JMP_REG  = 5'd14;
    localparam logic [4:0] JMP_MEM  = 5'd15;
    localparam logic [4:0] TRAP     = 5'd16;

    localparam logic [OP_W-1:0]    OP_R      = OP_W'(6'b000000);
    localparam logic [OP_W-1:0]    OP_LW     = OP_W'(6'b100011);
    localparam logic [OP_W-1:0]    OP_SW     = OP_W'(6'b101011);
    localparam logic [OP_W-1:0]    OP_BEQ    = OP_W'(6'b000100);
    localparam logic [OP_W-1:0]    OP_NANDI  = OP_W'(6'b010000);
    localparam logic [OP_W-1:0]    OP_JALPC  = OP_W'(6'b011111);
    localparam logic [OP_W-1:0]    OP_BALV   = OP_W'(6'b100000);
    localparam logic [OP_W-1:0]    OP_BLEZAL = OP_W'(6'b100100);
    localparam logic [FUNCT_W-1:0] FN_BRV    = FUNCT_W'(6'b010100);
    localparam logic [FUNCT_W-1:0] FN_JMXOR  = FUNCT_W'(6'b100010);

    logic [4:0]        state_reg, state_next;
    logic [FLAG_W-1:0] status_reg;
    logic              status_en;
    logic              is_brv, is_jmxor;

    logic       pc_write_d, iord_d, mem_read_d, mem_write_d, ir_write_d, reg_dst_d;
    logic       mem_to_reg_d, reg_write_d, link_write_d, alu_src_a_d, instr_done_d;
    logic [1:0] alu_src_b_d, alu_op_d, pc_src_d;

    assign is_brv   = (funct == FN_BRV);
    assign is_jmxor = (funct == FN_JMXOR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= FETCH;
            status_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (status_en)
                status_reg <= alu_flags;
        end
    end

    always_comb begin
        state_next   = state_reg;
        status_en    = 1'b0;
        pc_write_d   = 1'b0;
        iord_d       = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        ir_write_d   = 1'b0;
        reg_dst_d    = 1'b0;
        mem_to_reg_d = 1'b0;
        reg_write_d  = 1'b0;
        link_write_d = 1'b0;
        alu_src_a_d  = 1'b0;
        alu_src_b_d  = 2'b00;
        alu_op_d     = 2'b00;
        pc_src_d     = 2'b00;
        instr_done_d = 1'b0;
        case (state_reg)
            FETCH: begin
                mem_read_d  = 1'b1;
                alu_src_b_d = 2'b01;
                ir_write_d  = mem_ready;
                pc_write_d  = mem_ready;
                if (mem_ready)
                    state_next = DECODE;
            end
            DECODE: begin
                alu_src_b_d = 2'b11;
                case (opcode)
                    OP_R:               state_next = EXEC_R;
                    OP_LW, OP_SW:       state_next = MEM_ADDR;
                    OP_BEQ:             state_next = BEQ;
                    OP_NANDI:           state_next = EXEC_I;
                    OP_JALPC:           state_next = JALPC;
                    OP_BALV:            state_next = BALV;
                    OP_BLEZAL:          state_next = BLEZAL;
                    default:            state_next = TRAP;
                endcase
            end
            EXEC_R: begin
                alu_src_a_d = 1'b1;
                alu_op_d    = 2'b10;
                // Register-jump forms consume the old V flag, so they must not overwrite it
                status_en   = !(is_brv || is_jmxor);
                if (is_brv)
                    state_next = JMP_REG;
                else if (is_jmxor)
                    state_next = JMP_MEM;
                else
                    state_next = WB_R;
            end
            WB_R: begin
                reg_dst_d    = 1'b1;
                reg_write_d  = 1'b1;
                instr_done_d = 1'b1;
                state_next   = FETCH;
            end
            EXEC_I: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
                alu_op_d    = 2'b11;
                state_next  = WB_I;
            end
            WB_I: begin
                reg_write_d  = 1'b1;
                instr_done_d = 1'b1;
                state_next   = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
                status_en   = 1'b1;
                state_next  = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read_d = 1'b1;
                iord_d     = 1'b1;
                if (mem_ready)
                    state_next = MEM_WB;
            end
            MEM_WB: begin
                mem_to_reg_d = 1'b1;
                reg_write_d  = 1'b1;
                instr_done_d = 1'b1;
                state_next   = FETCH;
            end
            MEM_WR: begin
                mem_write_d  = 1'b1;
                iord_d       = 1'b1;
                instr_done_d = mem_ready;
                if (mem_ready)
                    state_next = FETCH;
            end
            BEQ: begin
                alu_src_a_d  = 1'b1;
                alu_op_d     = 2'b01;
                status_en    = 1'b1;
                pc_write_d   = alu_flags[0];
                pc_src_d     = 2'b01;
                instr_done_d = 1'b1;
                state_next   = FETCH;
            end
            JALPC: begin
                link_write_d = 1'b1;
                pc_write_d   = 1'b1;
                pc_src_d     = 2'b01;
                instr_done_d = 1'b1;
                state_next   = FETCH;
            end
            BALV: begin
                link_write_d = status_reg[2];
                pc_write_d   = status_reg[2];
                pc_src_d     = 2'b01;
                instr_done_d = 1'b1;
                state_next   = FETCH;
            end
            BLEZAL: begin
                alu_src_a_d  = 1'b1;
                alu_op_d     = 2'b01;
                link_write_d = alu_flags[0] | alu_flags[1];
                pc_write_d   = alu_flags[0] | alu_flags[1];
                pc_src_d     = 2'b01;
                instr_done_d = 1'b1;
                state_next   = FETCH;
            end
            JMP_REG: begin
                pc_write_d   = status_reg[2];
                pc_src_d     = 2'b11;
                instr_done_d = 1'b1;
                state_next   = FETCH;
            end
            JMP_MEM: begin
                mem_read_d   = 1'b1;
                iord_d       = 1'b1;
                pc_write_d   = mem_ready;
                pc_src_d     = 2'b10;
                instr_done_d = mem_ready;
                if (mem_ready)
                    state_next = FETCH;
            end
            TRAP:    state_next = TRAP;
            default: state_next = TRAP;
        endcase
    end

    // Reset forces every strobe low combinationally, even while the FSM sits in FETCH
    assign pc_write     = rst_n & pc_write_d;
    assign iord         = rst_n & iord_d;
    assign mem_read     = rst_n & mem_read_d;
    assign mem_write    = rst_n & mem_write_d;
    assign ir_write     = rst_n & ir_write_d;
    assign reg_dst      = rst_n & reg_dst_d;
    assign mem_to_reg   = rst_n & mem_to_reg_d;
    assign reg_write    = rst_n & reg_write_d;
    assign link_write   = rst_n & link_write_d;
    assign alu_src_a    = rst_n & alu_src_a_d;
    assign alu_src_b    = rst_n ? alu_src_b_d : 2'b00;
    assign alu_op       = rst_n ? alu_op_d : 2'b00;
    assign pc_src       = rst_n ? pc_src_d : 2'b00;
    assign instr_done   = rst_n & instr_done_d;
    assign status_flags = status_reg;
    assign illegal      = rst_n & (state_reg == TRAP);
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: a driver plans each instruction from its phase list and queues
// the expected completion; a monitor pops and checks on every instr_done.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       mem_ready = 1'b0;
    logic [2:0] alu_flags = '0;
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
    logic       reg_write, link_write, alu_src_a, instr_done, illegal;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [2:0] status_flags;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .alu_flags(alu_flags),
        .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .link_write(link_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .status_flags(status_flags), .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    wire [16:0] out_bus = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst,
                           mem_to_reg, reg_write, link_write, alu_src_a, alu_src_b,
                           alu_op, pc_src, instr_done};

    localparam int K_R = 0, K_BRV = 1, K_JMXOR = 2, K_NANDI = 3, K_LW = 4;
    localparam int K_SW = 5, K_BEQ = 6, K_JALPC = 7, K_BALV = 8, K_BLEZAL = 9;

    typedef struct {
        int         len;
        logic       pw, lw_, rw, m2r;
        logic [1:0] psrc;
        logic [2:0] status;
        int         kind;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    logic       mon_en = 1'b0;
    logic [2:0] model_status = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    // Reference: architectural effect and cycle count of one instruction
    task automatic run_instr(input int kind, input logic [2:0] f, input int wf, input int wm);
        exp_t e;
        int   seq[$];
        e.kind = kind; e.pw = 0; e.lw_ = 0; e.rw = 0; e.m2r = 0; e.psrc = 2'b00;
        funct = 6'($urandom);
        case (kind)
            K_R: begin
                opcode = 6'b000000;
                if (funct == 6'b010100 || funct == 6'b100010) funct = 6'b100000;
                e.rw = 1; model_status = f;
            end
            K_BRV:    begin opcode = 6'b000000; funct = 6'b010100; e.pw = model_status[2]; e.psrc = 2'b11; end
            K_JMXOR:  begin opcode = 6'b000000; funct = 6'b100010; e.pw = 1; e.psrc = 2'b10; end
            K_NANDI:  begin opcode = 6'b010000; e.rw = 1; end
            K_LW:     begin opcode = 6'b100011; e.rw = 1; e.m2r = 1; model_status = f; end
            K_SW:     begin opcode = 6'b101011; model_status = f; end
            K_BEQ:    begin opcode = 6'b000100; e.pw = f[0]; e.psrc = 2'b01; model_status = f; end
            K_JALPC:  begin opcode = 6'b011111; e.pw = 1; e.lw_ = 1; e.psrc = 2'b01; end
            K_BALV:   begin opcode = 6'b100000; e.pw = model_status[2]; e.lw_ = model_status[2]; e.psrc = 2'b01; end
            default:  begin opcode = 6'b100100; e.pw = f[0] | f[1]; e.lw_ = f[0] | f[1]; e.psrc = 2'b01; end
        endcase
        e.status = model_status;
        alu_flags = f;
        repeat (wf) seq.push_back(0);
        seq.push_back(1);
        seq.push_back(int'($urandom_range(0, 1)));
        case (kind)
            K_R, K_BRV, K_NANDI: begin
                seq.push_back(int'($urandom_range(0, 1)));
                seq.push_back(int'($urandom_range(0, 1)));
            end
            K_JMXOR, K_SW: begin
                seq.push_back(int'($urandom_range(0, 1)));
                repeat (wm) seq.push_back(0);
                seq.push_back(1);
            end
            K_LW: begin
                seq.push_back(int'($urandom_range(0, 1)));
                repeat (wm) seq.push_back(0);
                seq.push_back(1);
                seq.push_back(int'($urandom_range(0, 1)));
            end
            default: seq.push_back(int'($urandom_range(0, 1)));
        endcase
        e.len = seq.size();
        sb.push_back(e);
        foreach (seq[i]) begin
            mem_ready = seq[i][0];
            @(posedge clk); #1;
        end
    endtask

    // Monitor: counts cycles per instruction and checks each completion
    initial begin
        int   cnt;
        logic pend;
        logic [2:0] st_exp;
        exp_t e;
        cnt = 0; pend = 0; st_exp = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                cnt = 0; pend = 0;
            end else begin
                if (pend) begin
                    chk("status_after", 32'(status_flags), 32'(st_exp));
                    pend = 0;
                end
                if (pc_write && reg_write) chk("excl_pc_reg", 32'(1), 32'(0));
                if (mem_read && mem_write) chk("excl_rd_wr", 32'(1), 32'(0));
                cnt++;
                if (instr_done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'(1), 32'(0));
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("len_k%0d", e.kind), 32'(cnt), 32'(e.len));
                        chk($sformatf("pc_write_k%0d", e.kind), 32'(pc_write), 32'(e.pw));
                        chk($sformatf("link_write_k%0d", e.kind), 32'(link_write), 32'(e.lw_));
                        chk($sformatf("reg_write_k%0d", e.kind), 32'(reg_write), 32'(e.rw));
                        chk($sformatf("mem_to_reg_k%0d", e.kind), 32'(mem_to_reg), 32'(e.m2r));
                        chk($sformatf("pc_src_k%0d", e.kind), 32'(pc_src), 32'(e.psrc));
                        st_exp = e.status;
                        pend = 1;
                    end
                    cnt = 0;
                end else if (mem_to_reg) begin
                    chk("mem_to_reg_early", 32'(mem_to_reg), 32'(0));
                end else if (cnt > 40) begin
                    chk("done_timeout", 32'(cnt), 32'(0));
                    cnt = 0;
                end
            end
        end
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'(out_bus), 32'(0));
        chk("reset_status", 32'(status_flags), 32'(0));
        chk("reset_illegal", 32'(illegal), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        run_instr(K_LW, 3'b011, 2, 2);
        run_instr(K_R, 3'b100, 0, 0);
        run_instr(K_BALV, 3'b000, 0, 0);
        run_instr(K_R, 3'b000, 1, 0);
        run_instr(K_BALV, 3'b111, 0, 0);
        run_instr(K_R, 3'b100, 0, 0);
        run_instr(K_BRV, 3'b001, 0, 0);
        run_instr(K_BLEZAL, 3'b010, 0, 0);
        run_instr(K_BLEZAL, 3'b000, 0, 0);
        run_instr(K_BEQ, 3'b001, 0, 0);
        run_instr(K_JMXOR, 3'b101, 1, 3);
        run_instr(K_SW, 3'b110, 0, 2);
        for (int n = 0; n < 80; n++) begin
            k = int'($urandom_range(0, 9));
            run_instr(k, 3'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        repeat (2) @(negedge clk);
        #1 mon_en = 1'b0;
        chk("scoreboard_empty", 32'(sb.size()), 32'(0));

        // Asynchronous reset in the middle of a stalled load
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_pulse_outputs", 32'(out_bus), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        opcode = 6'b100011; alu_flags = 3'b101; mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("memrd_mem_read", 32'(mem_read), 32'(1));
        chk("memrd_status", 32'(status_flags), 32'(3'b101));
        #2 rst_n = 1'b0;
        #1;
        chk("async_mem_read", 32'(mem_read), 32'(0));
        chk("async_outputs", 32'(out_bus), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_mem_read", 32'(mem_read), 32'(1));
        chk("post_rst_iord", 32'(iord), 32'(0));
        chk("post_rst_status", 32'(status_flags), 32'(0));
        chk("post_rst_illegal", 32'(illegal), 32'(0));

        // Illegal opcode traps and stays trapped until reset
        opcode = 6'b111111; mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("decode_not_illegal", 32'(illegal), 32'(0));
        @(posedge clk); #1;
        for (int c = 0; c < 20; c++) begin
            mem_ready = 1'($urandom);
            alu_flags = 3'($urandom);
            @(negedge clk);
            chk($sformatf("trap_illegal_%0d", c), 32'(illegal), 32'(1));
            chk($sformatf("trap_outputs_%0d", c), 32'(out_bus), 32'(0));
        end
        rst_n = 1'b0;
        #1;
        chk("trap_cleared", 32'(illegal), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
